// File: rtl/pc_gen_bp.sv
// ---------------------------------------------------------------------------
// pc_gen_bp -- fetch-stage PC generator with a direct-mapped BTB.
//
// Holds the registered fetch PC and predicts the next fetch address from a
// BTB of 2-bit saturating counters. Branch/jump resolution from EX trains
// the BTB and redirects the PC, with a same-cycle flush of IF/ID, whenever
// the carried prediction was wrong. Exceptions redirect to EXC_VEC.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset
//   i_stall          hold the PC (IF/ID not accepting)
//   i_exc_req        exception taken this cycle
//   i_ex_valid       EX is resolving a control-transfer instruction
//   i_ex_is_jump     1 = unconditional jump, 0 = conditional branch
//   i_ex_pc          PC of the resolving instruction
//   i_ex_taken       actual direction
//   i_ex_target      actual target
//   i_ex_pred_taken  prediction carried with the instruction
//   i_ex_pred_target predicted target carried with the instruction
//   o_pc             current fetch address
//   o_pred_taken     BTB prediction for o_pc
//   o_pred_target    predicted next address for o_pc
//   o_flush          kill IF/ID contents this cycle
// ---------------------------------------------------------------------------
module pc_gen_bp #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
    parameter int          BTB_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_exc_req,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_jump,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic [31:0] o_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_flush
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_ex_pc_plus4;

    // Flattened views of the per-entry state, built by the generate loop.
    logic [BTB_DEPTH-1:0]            w_valid;
    logic [BTB_DEPTH-1:0][1:0]       w_ctr;
    logic [BTB_DEPTH-1:0][TAG_W-1:0] w_tag;
    logic [BTB_DEPTH-1:0][31:0]      w_tgt;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_pc_tag;
    logic             w_hit;

    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic [1:0]       w_ex_ctr;
    logic [1:0]       w_ctr_upd;
    logic             w_mp;
    logic             w_unused;

    assign w_unused = ^i_ex_pc[1:0];

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_ex_pc_plus4 = i_ex_pc + 32'd4;

    // ---------------- fetch-side lookup (combinational from pc) ----------
    assign w_idx         = r_pc[IDX_W+1:2];
    assign w_pc_tag      = r_pc[31:IDX_W+2];
    assign w_hit         = w_valid[w_idx] && (w_tag[w_idx] == w_pc_tag);
    assign o_pred_taken  = w_hit && w_ctr[w_idx][1];
    assign o_pred_target = w_hit ? w_tgt[w_idx] : w_pc_plus4;
    assign o_pc          = r_pc;

    // ---------------- resolution side -------------------------------------
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = i_ex_pc[31:IDX_W+2];
    assign w_ex_hit = w_valid[w_ex_idx] && (w_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_ctr = w_ctr[w_ex_idx];

    always_comb begin
        w_ctr_upd = w_ex_ctr;
        if (i_ex_taken) begin
            if (w_ex_ctr != 2'b11) w_ctr_upd = w_ex_ctr + 2'b01;
        end else begin
            if (w_ex_ctr != 2'b00) w_ctr_upd = w_ex_ctr - 2'b01;
        end
    end

    // A taken prediction is only correct if the target matches too.
    assign w_mp = i_ex_valid &&
                  ((i_ex_taken != i_ex_pred_taken) ||
                   (i_ex_taken && (i_ex_target != i_ex_pred_target)));

    assign o_flush = !i_rst && (i_exc_req || w_mp);

    // ---------------- next-pc selection -----------------------------------
    // Redirects sit above stall so a flush never leaves a stale PC behind.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (i_exc_req)
            w_pc_next = EXC_VEC;
        else if (w_mp)
            w_pc_next = i_ex_taken ? i_ex_target : w_ex_pc_plus4;
        else if (i_stall)
            w_pc_next = r_pc;
        else if (o_pred_taken)
            w_pc_next = o_pred_target;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_pc <= RESET_PC;
        else       r_pc <= w_pc_next;
    end

    // ---------------- BTB entries -----------------------------------------
    // Each entry only looks at its own select, so a lookup at the same index
    // during an update sees the pre-edge contents.
    genvar gi;
    generate
        for (gi = 0; gi < BTB_DEPTH; gi++) begin : g_entry
            logic             r_valid;
            logic [1:0]       r_ctr;
            logic [TAG_W-1:0] r_tag;
            logic [31:0]      r_tgt;
            logic             w_sel;

            assign w_sel = i_ex_valid && (w_ex_idx == IDX_W'(gi));

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_valid <= 1'b0;
                    r_ctr   <= 2'b00;
                end else if (w_sel) begin
                    if (w_ex_hit) begin
                        r_ctr <= w_ctr_upd;
                    end else if (i_ex_taken) begin
                        r_valid <= 1'b1;
                        r_ctr   <= i_ex_is_jump ? 2'b11 : 2'b10;
                    end
                end
            end

            // Tag/target need no reset; valid guards them.
            always_ff @(posedge i_clk) begin
                if (!i_rst && w_sel && i_ex_taken) begin
                    r_tgt <= i_ex_target;
                    if (!w_ex_hit) r_tag <= w_ex_tag;
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_ctr[gi]   = r_ctr;
            assign w_tag[gi]   = r_tag;
            assign w_tgt[gi]   = r_tgt;
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen_bp.sv
module tb_pc_gen_bp;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_exc_req;
    logic        i_ex_valid;
    logic        i_ex_is_jump;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic [31:0] o_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_flush;

    int checks   = 0;
    int failures = 0;

    pc_gen_bp dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_stall          (i_stall),
        .i_exc_req        (i_exc_req),
        .i_ex_valid       (i_ex_valid),
        .i_ex_is_jump     (i_ex_is_jump),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_target      (i_ex_target),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_pred_target (i_ex_pred_target),
        .o_pc             (o_pc),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .o_flush          (o_flush)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled around the falling edge.
    task automatic set_ex(input logic j, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        i_ex_valid = 1'b1; i_ex_is_jump = j; i_ex_pc = pc; i_ex_taken = tk;
        i_ex_target = tgt; i_ex_pred_taken = ptk; i_ex_pred_target = ptgt;
        $display("txn ex_pc=%h jump=%0d taken=%0d tgt=%h pred=%0d ptgt=%h stall=%0d exc=%0d rst=%0d",
                 pc, j, tk, tgt, ptk, ptgt, i_stall, i_exc_req, i_rst);
    endtask

    task automatic clear_ex();
        i_ex_valid = 1'b0; i_ex_is_jump = 1'b0; i_ex_pc = 32'h0; i_ex_taken = 1'b0;
        i_ex_target = 32'h0; i_ex_pred_taken = 1'b0; i_ex_pred_target = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge i_clk); @(negedge i_clk);
        checks++; if (o_pc !== 32'hBFC0_0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'hBFC0_0000); end
        checks++; if (o_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", o_pred_taken); end
        checks++; if (o_pred_target !== 32'hBFC0_0004) begin failures++; $display("FAIL reset_ptgt got=%h exp=%h", o_pred_target, 32'hBFC0_0004); end
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", o_flush); end
        i_rst = 1'b0;
        #1;
        checks++; if (o_pc !== 32'hBFC0_0000) begin failures++; $display("FAIL first_fetch got=%h exp=%h", o_pc, 32'hBFC0_0000); end
        @(negedge i_clk);
        checks++; if (o_pc !== 32'hBFC0_0004) begin failures++; $display("FAIL seq1 got=%h exp=%h", o_pc, 32'hBFC0_0004); end
        @(negedge i_clk);
        checks++; if (o_pc !== 32'hBFC0_0008) begin failures++; $display("FAIL seq2 got=%h exp=%h", o_pc, 32'hBFC0_0008); end
        checks++; if (o_pred_taken !== 1'b0 || o_flush !== 1'b0) begin failures++; $display("FAIL seq_pred_flush got=%b%b exp=00", o_pred_taken, o_flush); end
    endtask

    task automatic test_stall_redirect();
        i_stall = 1'b1;
        @(negedge i_clk);
        checks++; if (o_pc !== 32'hBFC0_0008) begin failures++; $display("FAIL stall_hold got=%h exp=%h", o_pc, 32'hBFC0_0008); end
        set_ex(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL stall_mp_flush got=%b exp=1", o_flush); end
        @(negedge i_clk);
        checks++; if (o_pc !== 32'h40) begin failures++; $display("FAIL stall_mp_pc got=%h exp=%h", o_pc, 32'h40); end
        clear_ex(); i_stall = 1'b0;
        #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h44) begin failures++; $display("FAIL pc40_miss got=%b/%h exp=0/%h", o_pred_taken, o_pred_target, 32'h44); end
    endtask

    task automatic test_btb_learn();
        set_ex(1'b0, 32'h40, 1'b1, 32'h20, 1'b0, 32'h0);
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL learn_flush got=%b exp=1", o_flush); end
        @(negedge i_clk);
        checks++; if (o_pc !== 32'h20) begin failures++; $display("FAIL learn_redirect got=%h exp=%h", o_pc, 32'h20); end
        clear_ex();
        for (int n = 0; n < 20; n++) begin
            if (o_pc == 32'h40) break;
            @(negedge i_clk);
        end
        checks++; if (o_pc !== 32'h40) begin failures++; $display("FAIL reach_40 got=%h exp=%h", o_pc, 32'h40); end
        #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h20) begin failures++; $display("FAIL learn_pred got=%b/%h exp=1/%h", o_pred_taken, o_pred_target, 32'h20); end
        // first not-taken: mispredict, falls through past the stall
        i_stall = 1'b1;
        set_ex(1'b0, 32'h40, 1'b0, 32'h20, 1'b1, 32'h20);
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL nt1_flush got=%b exp=1", o_flush); end
        @(negedge i_clk);
        checks++; if (o_pc !== 32'h44) begin failures++; $display("FAIL nt1_pc got=%h exp=%h", o_pc, 32'h44); end
        // return to 0x40 via a mispredicted branch at another index
        set_ex(1'b0, 32'h3C, 1'b1, 32'h40, 1'b0, 32'h0);
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'h40 || o_pred_taken !== 1'b0 || o_pred_target !== 32'h20) begin failures++; $display("FAIL ctr01 got=%h/%b/%h exp=%h/0/%h", o_pc, o_pred_taken, o_pred_target, 32'h40, 32'h20); end
        // second not-taken: correctly predicted, no flush
        set_ex(1'b0, 32'h40, 1'b0, 32'h20, 1'b0, 32'h20);
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL nt2_flush got=%b exp=0", o_flush); end
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'h40 || o_pred_taken !== 1'b0) begin failures++; $display("FAIL ctr00 got=%h/%b exp=%h/0", o_pc, o_pred_taken, 32'h40); end
    endtask

    task automatic test_saturation();
        logic exp_pt;
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b0, 32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
            #1;
            checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL sat_flush%0d got=%b exp=0", k, o_flush); end
            @(negedge i_clk);
            clear_ex();
            #1;
            exp_pt = (k >= 1);
            checks++; if (o_pred_taken !== exp_pt || o_pc !== 32'h40) begin failures++; $display("FAIL sat_inc%0d got=%b/%h exp=%b/%h", k, o_pred_taken, o_pc, exp_pt, 32'h40); end
        end
        set_ex(1'b0, 32'h40, 1'b0, 32'h20, 1'b0, 32'h20);
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h20) begin failures++; $display("FAIL sat_dec got=%b/%h exp=1/%h", o_pred_taken, o_pred_target, 32'h20); end
    endtask

    task automatic test_alias();
        set_ex(1'b1, 32'h440, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL alias_flush got=%b exp=0", o_flush); end
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'h40 || o_pred_taken !== 1'b0 || o_pred_target !== 32'h44) begin failures++; $display("FAIL alias_miss got=%h/%b/%h exp=%h/0/%h", o_pc, o_pred_taken, o_pred_target, 32'h40, 32'h44); end
        set_ex(1'b0, 32'h43C, 1'b0, 32'h0, 1'b1, 32'h0);
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'h440 || o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin failures++; $display("FAIL alias_new got=%h/%b/%h exp=%h/1/%h", o_pc, o_pred_taken, o_pred_target, 32'h440, 32'h80); end
        // jump allocated at 11: one not-taken still predicts taken
        set_ex(1'b0, 32'h440, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'h440 || o_pred_taken !== 1'b1) begin failures++; $display("FAIL jump_ctr11 got=%h/%b exp=%h/1", o_pc, o_pred_taken, 32'h440); end
    endtask

    task automatic test_wrap();
        i_stall = 1'b0;
        set_ex(1'b0, 32'h208, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'hFFFF_FFFC || o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin failures++; $display("FAIL wrap_ptgt got=%h/%b/%h exp=%h/0/%h", o_pc, o_pred_taken, o_pred_target, 32'hFFFF_FFFC, 32'h0); end
        @(negedge i_clk);
        checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", o_pc, 32'h0); end
        set_ex(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        @(negedge i_clk);
        clear_ex();
        #1;
        checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL wrap_fallthru got=%h exp=%h", o_pc, 32'h0); end
    endtask

    task automatic test_exception();
        i_stall = 1'b1; i_exc_req = 1'b1;
        set_ex(1'b1, 32'hBFC0_0380, 1'b1, 32'hBFC0_0400, 1'b0, 32'h0);
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL exc_flush got=%b exp=1", o_flush); end
        @(negedge i_clk);
        i_exc_req = 1'b0; clear_ex();
        #1;
        checks++; if (o_pc !== 32'hBFC0_0380 || o_pred_taken !== 1'b1 || o_pred_target !== 32'hBFC0_0400) begin failures++; $display("FAIL exc_pc_btb got=%h/%b/%h exp=%h/1/%h", o_pc, o_pred_taken, o_pred_target, 32'hBFC0_0380, 32'hBFC0_0400); end
        i_rst = 1'b1; i_exc_req = 1'b1;
        set_ex(1'b1, 32'hBFC0_0000, 1'b1, 32'h500, 1'b0, 32'h0);
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", o_flush); end
        @(negedge i_clk);
        i_rst = 1'b0; i_exc_req = 1'b0; i_stall = 1'b0; clear_ex();
        #1;
        checks++; if (o_pc !== 32'hBFC0_0000 || o_pred_taken !== 1'b0 || o_pred_target !== 32'hBFC0_0004) begin failures++; $display("FAIL rst_prio got=%h/%b/%h exp=%h/0/%h", o_pc, o_pred_taken, o_pred_target, 32'hBFC0_0000, 32'hBFC0_0004); end
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_exc_req = 1'b0;
        clear_ex();
        test_reset();
        test_stall_redirect();
        test_btb_learn();
        test_saturation();
        test_alias();
        test_wrap();
        test_exception();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen_bp.md
# pc_gen_bp

Parametrised fetch-stage PC generator for the 5-stage pipeline. It generalises the combinational next-PC selector into a registered PC with stall support and a direct-mapped branch target buffer (BTB). The BTB holds 2-bit saturating counters and predicts branches and jumps at fetch. Resolution arrives from EX, and the block redirects and flushes on mispredict or exception. It sits between the IF instruction-memory address port and the EX branch-resolution logic.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded by reset
- EXC_VEC, 32'hBFC0_0380, exception entry address
- BTB_DEPTH, 16, number of BTB entries; power of two, 2..256
- IDX_W, log2(BTB_DEPTH), derived; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold pc (IF/ID not accepting)
- exc_req  in  1  exception taken this cycle
- ex_valid  in  1  EX holds a control-transfer instruction being resolved
- ex_is_jump  in  1  unconditional (j/jal); 0 = conditional branch
- ex_pc  in  32  PC of the resolving instruction
- ex_taken  in  1  actual direction (1 for jumps)
- ex_target  in  32  actual target (pc+4+sext(imm)<<2, or {pc[31:28],idx,2'b00})
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction
- ex_pred_target  in  32  predicted target carried down the pipeline
- pc  out  32  current fetch address (register)
- pred_taken  out  1  BTB prediction for pc
- pred_target  out  32  predicted target for pc
- flush  out  1  kill IF/ID contents this cycle

## Operation
- No delay slot: fall-through is ex_pc+4; all adds are 32-bit, wrap modulo 2^32.
- Lookup (combinational from pc): hit = valid[idx] & tag[idx]==pc tag. pred_taken = hit & ctr[idx][1]. pred_target = hit ? tgt[idx] : pc+4.
- Mispredict: mp = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
- Next-pc priority at each edge:
  1. rst gives RESET_PC.
  2. exc_req gives EXC_VEC.
  3. mp gives ex_taken ? ex_target : ex_pc+4.
  4. stall holds pc.
  5. pred_taken gives pred_target.
  6. Otherwise pc+4.
- Redirect (exc_req or mp) overrides stall.
- flush = !rst & (exc_req | mp). It is combinational in the same cycle as detection and is never asserted for a correct prediction.
- BTB update applies on every cycle with ex_valid & !rst, independent of stall and exc_req, at entry idx(ex_pc):
  - Hit (tag match and valid): if ex_taken, ctr saturating-increments and tgt is set to ex_target. If not taken, ctr saturating-decrements (floor 2'b00); the entry stays valid.
  - Miss and taken: allocate (overwrite). valid=1, tag=ex_pc tag, tgt=ex_target, ctr = ex_is_jump ? 2'b11 : 2'b10.
  - Miss and not taken: no change.
- Read-during-write at the same index returns pre-edge contents.
- Reset clears all valid bits and counters; tag and target arrays need no reset.

## Timing
- Reset values: pc=RESET_PC, pred_taken=0, pred_target=RESET_PC+4, flush=0.
- The first fetch of RESET_PC occurs in the first cycle after rst deasserts.
- Zero-latency prediction: pred_* valid in the same cycle as pc.
- Redirect latency is 1 cycle: the corrected pc appears on the edge after mp or exc_req is seen.
- BTB writes become visible to lookup 1 cycle after the update edge.
- rst asserted mid-operation has priority over exc_req, mp, stall, and any BTB write in that cycle.

## Test plan
- Reset and sequential fetch: hold rst 2 cycles, then release with no ex_valid. pc = BFC0_0000, 0004, 0008; pred_taken=0; flush=0.
- Stall vs redirect: stall=1 alone holds pc at 0x0008. Then stall=1 with mp (ex_pc=0x0000, taken, target 0x0040, pred 0). flush=1 in that cycle and pc=0x0040 on the next edge.
- BTB learning:
  - Branch at 0x0040 resolves taken to 0x0020 while mispredicted. It allocates with ctr=10.
  - The next fetch of 0x0040 gives pred_taken=1 and pred_target=0x0020.
  - Two not-taken resolutions: the first gives ctr=01, pred_taken=0, with flush on the first. The second gives ctr=00 with no flush.
- Saturation: four taken resolutions on a hit entry leave ctr=11. One not-taken then gives ctr=10, still predicting taken.
- Aliasing and wrap, with BTB_DEPTH=16: a taken branch at 0x0000_0040 is followed by a taken branch at 0x0000_0440 (same index, different tag). The entry is overwritten, and a fetch of 0x0040 misses. Separately, pc=0xFFFF_FFFC with no prediction yields 0x0000_0000.
- Exception precedence: exc_req and mp in the same cycle with stall=1 give flush=1 and pc=BFC0_0380. The BTB update from ex is still applied. With rst also high, pc=RESET_PC and the BTB is unchanged from its cleared state.
